// File: rtl/m_pc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | m_pc_pkg : shared types and constants for the PC / fetch stage   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package m_pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_t;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : m_pc_pkg
`default_nettype wire

// File: rtl/m_pc_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | m_pc_if : instruction-memory request/acknowledge bus             |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface m_pc_if;
  import m_pc_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );

endinterface : m_pc_if
`default_nettype wire

// File: rtl/m_pc_next.sv
`default_nettype none
// +------------------------------------------------------------------+
// | m_pc_next : combinational next-PC selector (JR > J > BEQ > BNE)  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module m_pc_next
  import m_pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        eq,
  input  logic [31:0] imm_ext,
  input  logic        br_beq,
  input  logic        br_bne,
  input  logic        jmp,
  input  logic [25:0] jtarget,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        misaligned
);

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        br_taken;

  // Branch offset is in words; the shift drops the top two bits so the
  // add wraps modulo 2^32 like the rest of the datapath.
  always_comb begin
    pc_plus4  = pc + PC_INC;
    br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    j_target  = {pc_plus4[31:28], jtarget, 2'b00};
    br_taken  = (br_beq && eq) || (br_bne && !eq);
  end

  always_comb begin
    next_pc    = pc_plus4;
    redirect   = 1'b0;
    misaligned = 1'b0;
    if (jr) begin
      next_pc    = jr_addr;
      redirect   = 1'b1;
      misaligned = (jr_addr[1:0] != 2'b00);
    end else if (jmp) begin
      next_pc  = j_target;
      redirect = 1'b1;
    end else if (br_taken) begin
      next_pc  = br_target;
      redirect = 1'b1;
    end
  end

endmodule : m_pc_next
`default_nettype wire

// File: rtl/m_pc_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | m_pc_unit : PC register, fetch FSM and imem handshake            |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module m_pc_unit
  import m_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          eq,
  input  logic [31:0]   imm_ext,
  input  logic          br_beq,
  input  logic          br_bne,
  input  logic          jmp,
  input  logic [25:0]   jtarget,
  input  logic          jr,
  input  logic [31:0]   jr_addr,
  input  logic          stall,
  input  logic          halt,
  m_pc_if.master        imem,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic          exec,
  output logic          taken,
  output logic          err
);

  pc_state_t   state;
  logic        req;
  logic [31:0] next_pc;
  logic        redirect;
  logic        misaligned;

  m_pc_next u_next (
    .pc         (pc),
    .eq         (eq),
    .imm_ext    (imm_ext),
    .br_beq     (br_beq),
    .br_bne     (br_bne),
    .jmp        (jmp),
    .jtarget    (jtarget),
    .jr         (jr),
    .jr_addr    (jr_addr),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .redirect   (redirect),
    .misaligned (misaligned)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  // req/exec are registered alongside the state so they always track it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      req   <= 1'b0;
      exec  <= 1'b0;
      taken <= 1'b0;
      err   <= 1'b0;
    end else if (state != ST_IDLE && halt) begin
      state <= ST_HALT;
      req   <= 1'b0;
      exec  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
          req   <= 1'b1;
          exec  <= 1'b0;
        end
        ST_FETCH: begin
          if (imem.imem_ack) begin
            state <= ST_EXEC;
            req   <= 1'b0;
            exec  <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            exec <= 1'b0;
            if (misaligned) begin
              // Bad JR target: keep the PC, flag it and stop fetching.
              err   <= 1'b1;
              state <= ST_HALT;
              req   <= 1'b0;
            end else begin
              pc    <= next_pc;
              taken <= redirect;
              state <= ST_FETCH;
              req   <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          req  <= 1'b0;
          exec <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          req   <= 1'b0;
          exec  <= 1'b0;
        end
      endcase
    end
  end

endmodule : m_pc_unit
`default_nettype wire

// File: tb/tb_m_pc_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_m_pc_unit : directed, model-checked bench for m_pc_unit       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_m_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int S_IDLE  = 0;
  localparam int S_FETCH = 1;
  localparam int S_EXEC  = 2;
  localparam int S_HALT  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eq, br_beq, br_bne, jmp, jr, stall, halt;
  logic [31:0] imm_ext, jr_addr;
  logic [25:0] jtarget;
  logic [31:0] pc, pc_plus4;
  logic        exec, taken, err;

  m_pc_if imem_bus ();

  m_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .eq       (eq),
    .imm_ext  (imm_ext),
    .br_beq   (br_beq),
    .br_bne   (br_bne),
    .jmp      (jmp),
    .jtarget  (jtarget),
    .jr       (jr),
    .jr_addr  (jr_addr),
    .stall    (stall),
    .halt     (halt),
    .imem     (imem_bus),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .exec     (exec),
    .taken    (taken),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase, architectural PC and flags from the rules.
  int          m_st    = S_IDLE;
  logic [31:0] m_pc    = RST_PC;
  logic        m_taken = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] m_seq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = S_IDLE; m_pc = RST_PC; m_taken = 1'b0; m_err = 1'b0;
    end else if (m_st == S_IDLE) begin
      m_st = S_FETCH;
    end else if (halt) begin
      m_st = S_HALT;
    end else if (m_st == S_FETCH) begin
      if (imem_bus.imem_ack) m_st = S_EXEC;
    end else if (m_st == S_EXEC && !stall) begin
      m_seq = m_pc + 32'd4;
      m_st  = S_FETCH;
      if (jr) begin
        if (jr_addr % 4 != 0) begin
          m_err = 1'b1;
          m_st  = S_HALT;
        end else begin
          m_pc = jr_addr; m_taken = 1'b1;
        end
      end else if (jmp) begin
        m_pc = (m_seq & 32'hF000_0000) | ({6'b0, jtarget} * 32'd4);
        m_taken = 1'b1;
      end else if ((br_beq && eq) || (br_bne && !eq)) begin
        m_pc = m_seq + imm_ext * 32'd4;
        m_taken = 1'b1;
      end else begin
        m_pc = m_seq; m_taken = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("pc",        pc,                 m_pc);
    chk("imem_addr", imem_bus.imem_addr, m_pc);
    chk("pc_plus4",  pc_plus4,           m_pc + 32'd4);
    chk("imem_req",  {31'b0, imem_bus.imem_req}, {31'b0, (m_st == S_FETCH)});
    chk("exec",      {31'b0, exec},      {31'b0, (m_st == S_EXEC)});
    chk("taken",     {31'b0, taken},     {31'b0, m_taken});
    chk("err",       {31'b0, err},       {31'b0, m_err});
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    eq = 1'b0; br_beq = 1'b0; br_bne = 1'b0; jmp = 1'b0; jr = 1'b0;
    stall = 1'b0; halt = 1'b0; imm_ext = '0; jr_addr = '0; jtarget = '0;
    imem_bus.imem_ack = 1'b0;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (m_st != S_FETCH && n < 50) begin
      tick();
      n++;
    end
    if (m_st != S_FETCH) begin
      checks++;
      errors++;
      $display("FAIL wait_fetch: no FETCH state within 50 cycles, state %0d", m_st);
    end
  endtask

  task automatic run_instr(input logic i_beq, input logic i_bne, input logic i_eq,
                           input logic i_j, input logic [25:0] i_jt,
                           input logic i_jr, input logic [31:0] i_ja,
                           input logic [31:0] i_imm, input int ack_dly, input int stall_n);
    clear_ctl();
    br_beq = i_beq; br_bne = i_bne; eq = i_eq; jmp = i_j; jtarget = i_jt;
    jr = i_jr; jr_addr = i_ja; imm_ext = i_imm;
    wait_fetch();
    imem_bus.imem_ack = (ack_dly == 0);
    for (int d = 0; d < ack_dly; d++) begin
      tick();
      chk("req_held", {31'b0, imem_bus.imem_req}, 32'd1);
    end
    imem_bus.imem_ack = 1'b1;
    tick();
    imem_bus.imem_ack = 1'b0;
    stall = (stall_n > 0);
    for (int s = 0; s < stall_n; s++) begin
      chk("stall_exec", {31'b0, exec}, 32'd1);
      chk("stall_noreq", {31'b0, imem_bus.imem_req}, 32'd0);
      tick();
    end
    stall = 1'b0;
    tick();
    clear_ctl();
  endtask

  task automatic seq_instr(input int ack_dly, input int stall_n);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 26'd0, 1'b0, 32'd0, 32'd0, ack_dly, stall_n);
  endtask

  task automatic jr_to(input logic [31:0] a);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 26'd0, 1'b1, a, 32'd0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_ctl();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h100);
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'b0, imem_bus.imem_req}, 32'd0);
    tick();
    chk("first_req", {31'b0, imem_bus.imem_req}, 32'd1);

    seq_instr(0, 0);
    chk("seq1_pc", pc, 32'h104);
    seq_instr(0, 0);
    chk("seq2_pc", pc, 32'h108);
    chk("seq_taken", {31'b0, taken}, 32'd0);

    jr_to(32'h10);
    chk("jr10_pc", pc, 32'h10);
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 26'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, 0, 0);
    chk("beq_t_pc", pc, 32'h10);
    chk("beq_t_taken", {31'b0, taken}, 32'd1);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, 0, 0);
    chk("beq_nt_pc", pc, 32'h14);
    chk("beq_nt_taken", {31'b0, taken}, 32'd0);
    jr_to(32'h10);
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 26'd0, 1'b0, 32'd0, 32'd3, 0, 0);
    chk("bne_pc", pc, 32'h20);

    jr_to(32'h1000_0000);
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 26'h40, 1'b0, 32'd0, 32'd0, 0, 0);
    chk("j_pc", pc, 32'h1000_0100);
    chk("j_taken", {31'b0, taken}, 32'd1);
    jr_to(32'h1000_0000);
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 26'h40, 1'b1, 32'h200, 32'd0, 0, 0);
    chk("jr_prio_pc", pc, 32'h200);

    jr_to(32'hFFFF_FFFC);
    chk("pre_wrap_pc", pc, 32'hFFFF_FFFC);
    seq_instr(0, 3);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pp4", pc_plus4, 32'h4);
    seq_instr(2, 0);
    chk("ackdly_pc", pc, 32'h4);

    wait_fetch();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    imem_bus.imem_ack = 1'b1;
    repeat (3) tick();
    chk("halt_req", {31'b0, imem_bus.imem_req}, 32'd0);
    chk("halt_pc", pc, 32'h4);
    clear_ctl();

    do_reset();
    tick();
    chk("rst2_pc", pc, 32'h100);
    jr_to(32'h202);
    chk("mis_pc", pc, 32'h100);
    chk("mis_err", {31'b0, err}, 32'd1);
    imem_bus.imem_ack = 1'b1;
    repeat (4) tick();
    chk("mis_halt_req", {31'b0, imem_bus.imem_req}, 32'd0);
    chk("mis_err_sticky", {31'b0, err}, 32'd1);
    clear_ctl();

    do_reset();
    tick();
    chk("rst3_err", {31'b0, err}, 32'd0);
    seq_instr(0, 0);
    chk("recover_pc", pc, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_m_pc_unit
`default_nettype wire
